// File: rtl/cam_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cam_frame_ctrl
// Description : Capture sequencer for the camera pixel-clock domain. Arms on a
//               software start once sensor configuration is complete, aligns
//               to the next frame boundary, gates frame-buffer writes for a
//               requested number of frames (or continuously until stopped)
//               and flags frames/lines whose geometry is off-nominal.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   LINES_PER_FRAME  expected href pulses per frame
//   BYTES_PER_LINE   expected href-high cycles per line
//   FRAME_CNT_W      width of frame request / frame counter
// Ports:
//   i_pclk            camera pixel clock (only clock)
//   i_reset           synchronous active-high reset
//   i_config_done     sensor configuration complete
//   i_vsync           vertical sync, high = frame blanking
//   i_href            line valid
//   i_start           one-cycle capture request
//   i_stop            one-cycle request to stop after the current frame
//   i_continuous      sampled at start: 1 = run until stop
//   i_num_frames      sampled at start: frames to capture (0 means 1)
//   i_err_clr         clears the sticky error flags
//   o_capture_en      frame-buffer writes permitted
//   o_busy            sequencer not idle
//   o_frame_start     pulse on entry to capture
//   o_frame_done      pulse at the end of each captured frame
//   o_frame_abort     pulse when capture is dropped on loss of config_done
//   o_frames_captured frames completed since the last start (wraps)
//   o_err_frame_len   sticky: frame line count off-nominal
//   o_err_line_len    sticky: line length off-nominal (0 unless macro set)
// Build option:
//   CAM_LINE_CHECK_EN  enables the per-line byte counter and o_err_line_len
// ============================================================================
module cam_frame_ctrl #(
  parameter int LINES_PER_FRAME = 480,
  parameter int BYTES_PER_LINE  = 1280,
  parameter int FRAME_CNT_W     = 8
) (
  input  logic                   i_pclk,
  input  logic                   i_reset,
  input  logic                   i_config_done,
  input  logic                   i_vsync,
  input  logic                   i_href,
  input  logic                   i_start,
  input  logic                   i_stop,
  input  logic                   i_continuous,
  input  logic [FRAME_CNT_W-1:0] i_num_frames,
  input  logic                   i_err_clr,
  output logic                   o_capture_en,
  output logic                   o_busy,
  output logic                   o_frame_start,
  output logic                   o_frame_done,
  output logic                   o_frame_abort,
  output logic [FRAME_CNT_W-1:0] o_frames_captured,
  output logic                   o_err_frame_len,
  output logic                   o_err_line_len
);

  localparam logic [9:0] c_LINE_MAX  = 10'h3FF;
  localparam logic [9:0] c_LINES_EXP = 10'(LINES_PER_FRAME);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_SYNC  = 2'd1,
    ST_WAIT_FRAME = 2'd2,
    ST_CAPTURE    = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;

  logic                   r_vsync_q;
  logic                   r_vsync_qq;
  logic                   r_href_q;
  logic                   r_href_qq;
  logic                   w_vs_rise;
  logic                   w_vs_fall;
  logic                   w_hr_fall;

  logic                   w_arm;
  logic                   w_enter_capture;
  logic                   w_frame_end;
  logic                   w_abort;
  logic                   w_stop_set;
  logic [FRAME_CNT_W-1:0] w_remaining_dec;

  logic                   r_continuous;
  logic [FRAME_CNT_W-1:0] r_remaining;
  logic                   r_stop_pending;
  logic [FRAME_CNT_W-1:0] r_frames_captured;
  logic [9:0]             r_line_cnt;
  logic                   r_err_frame_len;
  logic                   r_frame_start;
  logic                   r_frame_done;
  logic                   r_frame_abort;

  // --------------------------------------------------------------------------
  // Sync input registers and edge detection (edges compare _q against _qq)
  // --------------------------------------------------------------------------
  always_ff @(posedge i_pclk) begin
    if (i_reset) begin
      r_vsync_q  <= 1'b0;
      r_vsync_qq <= 1'b0;
      r_href_q   <= 1'b0;
      r_href_qq  <= 1'b0;
    end else begin
      r_vsync_q  <= i_vsync;
      r_vsync_qq <= r_vsync_q;
      r_href_q   <= i_href;
      r_href_qq  <= r_href_q;
    end
  end

  assign w_vs_rise = r_vsync_q & ~r_vsync_qq;
  assign w_vs_fall = ~r_vsync_q & r_vsync_qq;
  assign w_hr_fall = ~r_href_q & r_href_qq;

  assign w_remaining_dec = r_remaining - FRAME_CNT_W'(1);

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge i_pclk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next state and event decode. Loss of config_done outranks stop and
  // frame completion, so an aborted frame never reports frame_done.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt     = r_state;
    w_arm           = 1'b0;
    w_enter_capture = 1'b0;
    w_frame_end     = 1'b0;
    w_abort         = 1'b0;
    w_stop_set      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start && i_config_done) begin
          w_arm       = 1'b1;
          w_state_nxt = ST_WAIT_SYNC;
        end
      end
      ST_WAIT_SYNC: begin
        if (!i_config_done) begin
          w_abort     = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (i_stop) begin
          w_state_nxt = ST_IDLE;
        end else if (r_vsync_q) begin
          // Only a blanking interval guarantees the next falling edge is a
          // true frame start, so arming mid-frame waits here.
          w_state_nxt = ST_WAIT_FRAME;
        end
      end
      ST_WAIT_FRAME: begin
        if (!i_config_done) begin
          w_abort     = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (i_stop) begin
          w_state_nxt = ST_IDLE;
        end else if (w_vs_fall) begin
          w_enter_capture = 1'b1;
          w_state_nxt     = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (!i_config_done) begin
          w_abort     = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_stop_set = i_stop;
          if (w_vs_rise) begin
            w_frame_end = 1'b1;
            // A stop arriving on the closing cycle itself is honoured too.
            if (!(r_stop_pending || i_stop) &&
                (r_continuous || (w_remaining_dec != '0))) begin
              w_state_nxt = ST_WAIT_FRAME;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: pulses, capture parameters, frame/line counting, frame error
  // --------------------------------------------------------------------------
  always_ff @(posedge i_pclk) begin
    if (i_reset) begin
      r_frame_start     <= 1'b0;
      r_frame_done      <= 1'b0;
      r_frame_abort     <= 1'b0;
      r_continuous      <= 1'b0;
      r_remaining       <= '0;
      r_stop_pending    <= 1'b0;
      r_frames_captured <= '0;
      r_line_cnt        <= '0;
      r_err_frame_len   <= 1'b0;
    end else begin
      r_frame_start <= w_enter_capture;
      r_frame_done  <= w_frame_end;
      r_frame_abort <= w_abort;

      if (w_arm) begin
        r_continuous      <= i_continuous;
        r_remaining       <= (i_num_frames == '0) ? FRAME_CNT_W'(1) : i_num_frames;
        r_frames_captured <= '0;
      end else if (w_frame_end) begin
        r_frames_captured <= r_frames_captured + FRAME_CNT_W'(1);
        if (!r_continuous) begin
          r_remaining <= w_remaining_dec;
        end
      end

      if (w_state_nxt == ST_IDLE) begin
        r_stop_pending <= 1'b0;
      end else if (w_stop_set) begin
        r_stop_pending <= 1'b1;
      end

      if (w_enter_capture) begin
        r_line_cnt <= '0;
      end else if ((r_state == ST_CAPTURE) && w_hr_fall && (r_line_cnt != c_LINE_MAX)) begin
        r_line_cnt <= r_line_cnt + 10'd1;
      end

      // Set has priority over clear so a coincident error is never lost.
      if (w_frame_end && (r_line_cnt != c_LINES_EXP)) begin
        r_err_frame_len <= 1'b1;
      end else if (i_err_clr) begin
        r_err_frame_len <= 1'b0;
      end
    end
  end

`ifdef CAM_LINE_CHECK_EN
  // --------------------------------------------------------------------------
  // Optional line-length check: counts href-high cycles within each line
  // --------------------------------------------------------------------------
  localparam logic [10:0] c_BYTE_MAX  = 11'h7FF;
  localparam logic [10:0] c_BYTES_EXP = 11'(BYTES_PER_LINE);

  logic [10:0] r_byte_cnt;
  logic        r_err_line_len;
  logic        w_line_end;

  assign w_line_end = (r_state == ST_CAPTURE) && w_hr_fall;

  always_ff @(posedge i_pclk) begin
    if (i_reset) begin
      r_byte_cnt     <= '0;
      r_err_line_len <= 1'b0;
    end else begin
      if (w_enter_capture || w_line_end) begin
        r_byte_cnt <= '0;
      end else if ((r_state == ST_CAPTURE) && r_href_q && (r_byte_cnt != c_BYTE_MAX)) begin
        r_byte_cnt <= r_byte_cnt + 11'd1;
      end

      if (w_line_end && (r_byte_cnt != c_BYTES_EXP)) begin
        r_err_line_len <= 1'b1;
      end else if (i_err_clr) begin
        r_err_line_len <= 1'b0;
      end
    end
  end

  assign o_err_line_len = r_err_line_len;
`else
  assign o_err_line_len = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign o_capture_en      = (r_state == ST_CAPTURE);
  assign o_busy            = (r_state != ST_IDLE);
  assign o_frame_start     = r_frame_start;
  assign o_frame_done      = r_frame_done;
  assign o_frame_abort     = r_frame_abort;
  assign o_frames_captured = r_frames_captured;
  assign o_err_frame_len   = r_err_frame_len;

endmodule
`default_nettype wire

// File: tb/tb_cam_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cam_frame_ctrl
// Description : Self-checking bench for cam_frame_ctrl using a reduced frame
//               geometry. Expected per-frame results are queued as each frame
//               is driven and compared when frame_done appears.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cam_frame_ctrl;

  localparam int LPF = 6;
  localparam int BPL = 8;
  localparam int FW  = 8;

  logic          pclk = 1'b0;
  logic          reset;
  logic          config_done;
  logic          vsync;
  logic          href;
  logic          start;
  logic          stop;
  logic          continuous;
  logic [FW-1:0] num_frames;
  logic          err_clr;
  logic          capture_en;
  logic          busy;
  logic          frame_start;
  logic          frame_done;
  logic          frame_abort;
  logic [FW-1:0] frames_captured;
  logic          err_frame_len;
  logic          err_line_len;

  cam_frame_ctrl #(
    .LINES_PER_FRAME (LPF),
    .BYTES_PER_LINE  (BPL),
    .FRAME_CNT_W     (FW)
  ) u_dut (
    .i_pclk            (pclk),
    .i_reset           (reset),
    .i_config_done     (config_done),
    .i_vsync           (vsync),
    .i_href            (href),
    .i_start           (start),
    .i_stop            (stop),
    .i_continuous      (continuous),
    .i_num_frames      (num_frames),
    .i_err_clr         (err_clr),
    .o_capture_en      (capture_en),
    .o_busy            (busy),
    .o_frame_start     (frame_start),
    .o_frame_done      (frame_done),
    .o_frame_abort     (frame_abort),
    .o_frames_captured (frames_captured),
    .o_err_frame_len   (err_frame_len),
    .o_err_line_len    (err_line_len)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    int fc;
    int efl;
    int ell;
    int cap;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks  = 0;
  int   n_fail    = 0;
  int   n_start   = 0;
  int   n_done    = 0;
  int   n_abort   = 0;
  int   cap_total = 0;
  int   cap_run   = 0;
  int   fc_model  = 0;
  int   low_ticks = 0;
  int   line_check;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n clocks; inputs change 1 ns after the edge, outputs read there.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge pclk);
      if (vsync == 1'b0) low_ticks++;
      #1;
    end
  endtask

  task automatic pulse_start(input logic cont, input int n);
    start      = 1'b1;
    continuous = cont;
    num_frames = FW'(n);
    tick(1);
    start      = 1'b0;
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
  endtask

  // One frame: blanking, vsync low, lines, then vsync raised (left high).
  task automatic send_frame(input int lines, input int bad_line, input int bad_len,
                            input int stop_line, input int abort_line);
    int len;
    tick(2);
    vsync     = 1'b0;
    low_ticks = 0;
    tick(3);
    for (int l = 0; l < lines; l++) begin
      len = (l == bad_line) ? bad_len : BPL;
      if (l == stop_line)  stop = 1'b1;
      if (l == abort_line) config_done = 1'b0;
      href = 1'b1;
      tick(1);
      stop        = 1'b0;
      config_done = 1'b1;
      tick(len - 1);
      href = 1'b0;
      tick(3);
    end
    vsync = 1'b1;
  endtask

  // Capture-enable duration equals the vsync-low span seen at the pin.
  task automatic push_exp(input int efl, input int ell);
    exp_t e;
    fc_model++;
    e.fc  = fc_model;
    e.efl = efl;
    e.ell = ell;
    e.cap = low_ticks;
    exp_q.push_back(e);
  endtask

  task automatic check_all_zero(input string pfx);
    check_eq({pfx, "_capture_en"},  int'(capture_en), 0);
    check_eq({pfx, "_busy"},        int'(busy), 0);
    check_eq({pfx, "_frame_start"}, int'(frame_start), 0);
    check_eq({pfx, "_frame_done"},  int'(frame_done), 0);
    check_eq({pfx, "_frame_abort"}, int'(frame_abort), 0);
    check_eq({pfx, "_frames_cap"},  int'(frames_captured), 0);
    check_eq({pfx, "_err_frame"},   int'(err_frame_len), 0);
    check_eq({pfx, "_err_line"},    int'(err_line_len), 0);
  endtask

  // Output monitor / scoreboard consumer
  always @(negedge pclk) begin
    exp_t e;
    if (!reset) begin
      if (frame_start) begin
        n_start++;
        cap_run = 0;
      end
      if (capture_en) begin
        cap_total++;
        cap_run++;
      end
      if (frame_abort) n_abort++;
      if (frame_done) begin
        n_done++;
        if (exp_q.size() == 0) begin
          check_eq("unexpected_frame_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check_eq("sb_frames_captured", int'(frames_captured), e.fc);
          check_eq("sb_err_frame_len",   int'(err_frame_len), e.efl);
          check_eq("sb_err_line_len",    int'(err_line_len), e.ell);
          check_eq("sb_capture_cycles",  cap_run, e.cap);
          check_eq("sb_capture_en_low",  int'(capture_en), 0);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    n_fail++;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int snap_cap;
    int snap_done;
    int snap_start;
    int snap_abort;

`ifdef CAM_LINE_CHECK_EN
    line_check = 1;
`else
    line_check = 0;
`endif
    reset       = 1'b1;
    config_done = 1'b0;
    vsync       = 1'b1;
    href        = 1'b0;
    start       = 1'b0;
    stop        = 1'b0;
    continuous  = 1'b0;
    num_frames  = '0;
    err_clr     = 1'b0;
    tick(3);
    check_all_zero("reset");
    reset = 1'b0;
    tick(2);

    // start without config_done is ignored
    pulse_start(1'b0, 1);
    check_eq("start_no_cfg_busy", int'(busy), 0);
    config_done = 1'b1;
    tick(2);

    // single frame
    pulse_start(1'b0, 1);
    fc_model = 0;
    check_eq("start_latency_busy", int'(busy), 1);
    send_frame(LPF, -1, 0, -1, -1);
    push_exp(0, 0);
    tick(6);
    check_eq("single_busy", int'(busy), 0);
    check_eq("single_n_start", n_start, 1);
    check_eq("single_n_done", n_done, 1);
    check_eq("single_frames_captured", int'(frames_captured), 1);

    // multi-frame: 3 requested across 4 frames
    pulse_start(1'b0, 3);
    fc_model = 0;
    for (int f = 0; f < 3; f++) begin
      send_frame(LPF, -1, 0, -1, -1);
      push_exp(0, 0);
      tick(4);
    end
    snap_cap  = cap_total;
    snap_done = n_done;
    send_frame(LPF, -1, 0, -1, -1);
    tick(6);
    check_eq("multi_cap_in_4th", cap_total - snap_cap, 0);
    check_eq("multi_done_in_4th", n_done - snap_done, 0);
    check_eq("multi_frames_captured", int'(frames_captured), 3);
    check_eq("multi_busy", int'(busy), 0);

    // continuous with stop mid-frame 2 (num_frames 0 treated as 1 but ignored)
    pulse_start(1'b1, 0);
    fc_model = 0;
    send_frame(LPF, -1, 0, -1, -1);
    push_exp(0, 0);
    tick(4);
    send_frame(LPF, -1, 0, 2, -1);
    push_exp(0, 0);
    tick(4);
    snap_cap = cap_total;
    send_frame(LPF, -1, 0, -1, -1);
    tick(6);
    check_eq("cont_cap_after_stop", cap_total - snap_cap, 0);
    check_eq("cont_frames_captured", int'(frames_captured), 2);
    check_eq("cont_busy", int'(busy), 0);

    // short frame
    pulse_start(1'b0, 1);
    fc_model = 0;
    send_frame(LPF - 1, -1, 0, -1, -1);
    push_exp(1, 0);
    tick(6);
    check_eq("short_err_frame_len", int'(err_frame_len), 1);
    pulse_err_clr();
    check_eq("short_err_cleared", int'(err_frame_len), 0);

    // short line (flag only exists with the line check built in)
    pulse_start(1'b0, 1);
    fc_model = 0;
    send_frame(LPF, 2, BPL - 2, -1, -1);
    push_exp(0, line_check);
    tick(6);
    check_eq("line_err_line_len", int'(err_line_len), line_check);
    check_eq("line_err_frame_len", int'(err_frame_len), 0);
    pulse_err_clr();
    check_eq("line_err_cleared", int'(err_line_len), 0);

    // arm mid-frame: no capture until the next vsync high->low
    tick(2);
    snap_cap   = cap_total;
    snap_start = n_start;
    vsync = 1'b0;
    tick(3);
    href = 1'b1;
    tick(2);
    pulse_start(1'b0, 1);
    fc_model = 0;
    tick(4);
    href = 1'b0;
    tick(3);
    href = 1'b1;
    tick(BPL);
    href = 1'b0;
    tick(3);
    check_eq("midarm_busy", int'(busy), 1);
    vsync = 1'b1;
    tick(3);
    check_eq("midarm_no_capture", cap_total - snap_cap, 0);
    check_eq("midarm_no_start", n_start - snap_start, 0);
    send_frame(LPF, -1, 0, -1, -1);
    push_exp(0, 0);
    tick(6);
    check_eq("midarm_frames_captured", int'(frames_captured), 1);
    check_eq("midarm_busy_end", int'(busy), 0);

    // abort by loss of config_done in the second of two frames
    pulse_start(1'b0, 2);
    fc_model = 0;
    send_frame(LPF, -1, 0, -1, -1);
    push_exp(0, 0);
    tick(4);
    snap_abort = n_abort;
    snap_done  = n_done;
    send_frame(LPF, -1, 0, -1, 2);
    tick(6);
    check_eq("abort_pulses", n_abort - snap_abort, 1);
    check_eq("abort_no_done", n_done - snap_done, 0);
    check_eq("abort_frames_captured", int'(frames_captured), 1);
    check_eq("abort_busy", int'(busy), 0);

    // reset mid-capture
    pulse_start(1'b0, 1);
    tick(2);
    vsync = 1'b0;
    tick(4);
    check_eq("rst_mid_capture_en", int'(capture_en), 1);
    reset = 1'b1;
    tick(1);
    check_all_zero("rst_mid");
    reset = 1'b0;
    vsync = 1'b1;
    tick(4);
    check_eq("rst_mid_busy_after", int'(busy), 0);

    check_eq("sb_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
